// File: rtl/ram_scrub_master.sv
// RAM scrubber: writes a known pattern over a word range, reads it back and counts mismatching words.
// Define RAM_SCRUB_LFSR_EN to use a 32-bit Galois LFSR data pattern instead of the address pattern.
module ram_scrub_master #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DEPTH  = 5120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   length,
  input  logic              irq_clear,
  output logic              busy,
  output logic              done_irq,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [31:0]       writedata,
  input  logic [31:0]       readdata,
  output logic              clken
);

  localparam int unsigned       CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`ifdef RAM_SCRUB_LFSR_EN
  localparam logic [31:0]       LFSR_SEED = 32'hACE1_0001;
  localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;
`endif

  typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN, ST_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  len_clamp_c;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] nxt_addr_q, nxt_addr_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              chipselect_q, chipselect_d;
  logic              write_q, write_d;
  logic [3:0]        byteenable_q, byteenable_d;
  logic [31:0]       writedata_q, writedata_d;
  logic              busy_q, busy_d;
  logic              done_irq_q, done_irq_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [31:0]       cmp_exp_q, cmp_exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic              issue_c, issue_wr_c, phase_first_c;
  logic [ADDR_W-1:0] issue_addr_c;
`ifdef RAM_SCRUB_LFSR_EN
  logic [31:0]       lfsr_q, lfsr_d, lfsr_cur_c;
`endif

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a >= LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

`ifdef RAM_SCRUB_LFSR_EN
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction
`else
  function automatic logic [31:0] addr_pattern(input logic [ADDR_W-1:0] a);
    return 32'({3'b000, a, 3'b111, ~a});
  endfunction
`endif

  // Next-state, bus issue and readback compare; bus signals are registered so they align with state_q
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    base_d        = base_q;
    nxt_addr_d    = nxt_addr_q;
    address_d     = address_q;
    chipselect_d  = 1'b0;
    write_d       = 1'b0;
    byteenable_d  = 4'h0;
    writedata_d   = 32'h0;
    done_irq_d    = done_irq_q;
    err_count_d   = err_count_q;
    first_err_d   = first_err_q;
    cmp_vld_d     = chipselect_q & ~write_q;
    cmp_exp_d     = writedata_q;
    cmp_addr_d    = address_q;
    issue_c       = 1'b0;
    issue_wr_c    = 1'b0;
    phase_first_c = 1'b0;
    issue_addr_c  = nxt_addr_q;
    len_clamp_c   = (length > DEPTH_C) ? DEPTH_C : length;
`ifdef RAM_SCRUB_LFSR_EN
    lfsr_d        = lfsr_q;
    lfsr_cur_c    = lfsr_q;
`endif

    if (irq_clear) done_irq_d = 1'b0;

    // readdata belongs to the read that was on the bus one cycle earlier
    if (cmp_vld_q && (readdata != cmp_exp_q)) begin
      if (err_count_q != DEPTH_C) err_count_d = err_count_q + CNT_W'(1);
      if (err_count_q == '0)      first_err_d = cmp_addr_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          err_count_d = '0;
          first_err_d = '0;
          done_irq_d  = 1'b0;
          len_d       = len_clamp_c;
          base_d      = base;
          if (len_clamp_c == '0) begin
            state_d    = ST_DONE;
            done_irq_d = 1'b1;
          end else begin
            state_d       = ST_WRITE;
            issue_c       = 1'b1;
            issue_wr_c    = 1'b1;
            phase_first_c = 1'b1;
            issue_addr_c  = base;
          end
        end
      end
      ST_WRITE: begin
        if (cnt_q == len_q) begin
          state_d       = ST_READ;
          issue_c       = 1'b1;
          phase_first_c = 1'b1;
          issue_addr_c  = base_q;
        end else begin
          issue_c    = 1'b1;
          issue_wr_c = 1'b1;
        end
      end
      ST_READ: begin
        if (cnt_q == len_q) state_d = ST_DRAIN;
        else                issue_c = 1'b1;
      end
      ST_DRAIN: begin
        state_d    = ST_DONE;
        done_irq_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue_c) begin
      address_d    = issue_addr_c;
      chipselect_d = 1'b1;
      write_d      = issue_wr_c;
      byteenable_d = 4'hF;
      nxt_addr_d   = addr_inc(issue_addr_c);
      cnt_d        = phase_first_c ? CNT_W'(1) : cnt_q + CNT_W'(1);
`ifdef RAM_SCRUB_LFSR_EN
      lfsr_cur_c   = phase_first_c ? LFSR_SEED : lfsr_q;
      writedata_d  = lfsr_cur_c;
      lfsr_d       = lfsr_step(lfsr_cur_c);
`else
      writedata_d  = addr_pattern(issue_addr_c);
`endif
    end

    busy_d = (state_d == ST_WRITE) || (state_d == ST_READ) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      base_q       <= '0;
      nxt_addr_q   <= '0;
      address_q    <= '0;
      chipselect_q <= 1'b0;
      write_q      <= 1'b0;
      byteenable_q <= 4'h0;
      writedata_q  <= 32'h0;
      busy_q       <= 1'b0;
      done_irq_q   <= 1'b0;
      err_count_q  <= '0;
      first_err_q  <= '0;
      cmp_vld_q    <= 1'b0;
      cmp_exp_q    <= 32'h0;
      cmp_addr_q   <= '0;
`ifdef RAM_SCRUB_LFSR_EN
      lfsr_q       <= 32'h0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      base_q       <= base_d;
      nxt_addr_q   <= nxt_addr_d;
      address_q    <= address_d;
      chipselect_q <= chipselect_d;
      write_q      <= write_d;
      byteenable_q <= byteenable_d;
      writedata_q  <= writedata_d;
      busy_q       <= busy_d;
      done_irq_q   <= done_irq_d;
      err_count_q  <= err_count_d;
      first_err_q  <= first_err_d;
      cmp_vld_q    <= cmp_vld_d;
      cmp_exp_q    <= cmp_exp_d;
      cmp_addr_q   <= cmp_addr_d;
`ifdef RAM_SCRUB_LFSR_EN
      lfsr_q       <= lfsr_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign done_irq       = done_irq_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;
  assign address        = address_q;
  assign chipselect     = chipselect_q;
  assign write          = write_q;
  assign byteenable     = byteenable_q;
  assign writedata      = writedata_q;
  assign clken          = 1'b1;

endmodule

// File: tb/tb_ram_scrub_master.sv
// Bench for ram_scrub_master: latency-1 RAM model with read corruption, pass-level reference model and bus monitor.
`timescale 1ns/1ps
module tb_ram_scrub_master;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DEPTH  = 5120;
  localparam int unsigned CNT_W  = ADDR_W + 1;
`ifdef RAM_SCRUB_LFSR_EN
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
`endif

  logic              clk = 1'b0;
  logic              reset, start, irq_clear;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  length;
  logic              busy, done_irq, chipselect, write, clken;
  logic [CNT_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr, address;
  logic [3:0]        byteenable;
  logic [31:0]       writedata, readdata;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [31:0]       data;
  } acc_t;

  acc_t        exp_q[$];
  logic [31:0] mem     [DEPTH];
  logic [31:0] corrupt [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  ram_scrub_master #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .length(length),
    .irq_clear(irq_clear), .busy(busy), .done_irq(done_irq), .err_count(err_count),
    .first_err_addr(first_err_addr), .address(address), .chipselect(chipselect),
    .write(write), .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
    .clken(clken)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // RAM with one-cycle read latency; corrupt[] flips bits on the way out
  always @(posedge clk) begin
    if (chipselect && write)  mem[address] <= writedata;
    if (chipselect && !write) readdata     <= mem[address] ^ corrupt[address];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every bus access must be the next one the reference model predicted
  always @(negedge clk) begin
    acc_t e;
    if (!reset && chipselect) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_access", {51'd0, address}, 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("acc_addr", 64'(address), 64'(e.addr));
        check_eq("acc_write", 64'(write), 64'(e.wr));
        if (e.wr) begin
          check_eq("acc_wdata", 64'(writedata), 64'(e.data));
          check_eq("acc_byteen", 64'(byteenable), 64'hF);
        end
      end
    end
  end

`ifdef RAM_SCRUB_LFSR_EN
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] poly;
    poly = '0;
    poly[31] = 1'b1; poly[21] = 1'b1; poly[1] = 1'b1; poly[0] = 1'b1;
    return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
  endfunction
`endif

  task automatic clear_corrupt();
    for (int i = 0; i < int'(DEPTH); i++) corrupt[i] = 32'h0;
  endtask

  // Builds the expected access list and pass results, returns expected error summary
  task automatic build_expect(input int b, input int n, output int exp_err, output int exp_first);
    int                a;
    logic [31:0]       d;
    logic [ADDR_W-1:0] aw;
    logic [31:0]       v;
    exp_err = 0;
    exp_first = 0;
    for (int ph = 0; ph < 2; ph++) begin
`ifdef RAM_SCRUB_LFSR_EN
      v = LFSR_SEED;
`else
      v = 32'h0;
`endif
      for (int k = 0; k < n; k++) begin
        a  = (b + k) % int'(DEPTH);
        aw = ADDR_W'(a);
`ifdef RAM_SCRUB_LFSR_EN
        d = v;
        v = lfsr_next(v);
`else
        d = {3'b000, aw, 3'b111, ~aw} ^ v;
`endif
        exp_q.push_back('{addr: aw, wr: (ph == 0), data: d});
        if (ph == 1 && corrupt[a] != 32'h0) begin
          if (exp_err == 0) exp_first = a;
          exp_err++;
        end
      end
    end
    if (exp_err > int'(DEPTH)) exp_err = int'(DEPTH);
  endtask

  task automatic run_pass(input int b, input int l, input bit disturb);
    int n, cyc, busy_cnt, done_cyc, limit, exp_err, exp_first;
    n = (l > int'(DEPTH)) ? int'(DEPTH) : l;
    build_expect(b, n, exp_err, exp_first);
    @(negedge clk);
    start = 1'b1; base = ADDR_W'(b); length = CNT_W'(l);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; busy_cnt = 0; done_cyc = 0; limit = 2 * n + 8;
    while (done_cyc == 0 && cyc <= limit) begin
      if (done_irq) begin
        done_cyc = cyc;
      end else begin
        if (busy) busy_cnt++;
        start = 1'b0;
        irq_clear = 1'b0;
        if (disturb && (cyc == 2 || cyc == 6)) begin
          start  = 1'b1;
          base   = ADDR_W'($urandom_range(0, DEPTH - 1));
          length = CNT_W'($urandom_range(1, 40));
        end
        if (disturb && cyc == 2 * n + 1) irq_clear = 1'b1;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    irq_clear = 1'b0;
    check_eq("done_cycle", 64'(done_cyc), 64'((n == 0) ? 1 : 2 * n + 2));
    check_eq("busy_cycles", 64'(busy_cnt), 64'((n == 0) ? 0 : 2 * n + 1));
    check_eq("busy_in_done", 64'(busy), 64'd0);
    check_eq("err_count", 64'(err_count), 64'(exp_err));
    check_eq("first_err_addr", 64'(first_err_addr), 64'(exp_first));
    check_eq("accesses_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    if (disturb) begin
      @(negedge clk);
      check_eq("irq_hold", 64'(done_irq), 64'd1);
    end
  endtask

  initial begin
    int found;
    reset = 1'b1; start = 1'b0; irq_clear = 1'b0; base = '0; length = '0;
    clear_corrupt();
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done_irq", 64'(done_irq), 64'd0);
    check_eq("rst_err_count", 64'(err_count), 64'd0);
    check_eq("rst_first_err", 64'(first_err_addr), 64'd0);
    check_eq("rst_bus", {19'd0, address, chipselect, write, byteenable, writedata}, 64'd0);
    check_eq("rst_clken", 64'(clken), 64'd1);
    reset = 1'b0;

    // empty pass from IDLE
    run_pass($urandom_range(0, DEPTH - 1), 0, 1'b0);
    // basic pass, wrap at top of RAM, single corrupted word
    run_pass(0, 16, 1'b0);
    run_pass(5118, 4, 1'b0);
    corrupt[7] = 32'h0000_0100;
    run_pass(0, 16, 1'b0);
    clear_corrupt();

    // reset mid-pass at read index 5
    build_expect(0, 16, found, found);
    @(negedge clk); start = 1'b1; base = '0; length = CNT_W'(16);
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (chipselect && !write && address == ADDR_W'(5)) begin
        found = 1;
        break;
      end
    end
    check_eq("reach_read5", 64'(found), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_cs", 64'(chipselect), 64'd0);
    check_eq("midrst_write", 64'(write), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_done_irq", 64'(done_irq), 64'd0);
    exp_q.delete();
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("postrst_idle", {62'd0, busy, chipselect}, 64'd0);

    // stray starts during WRITE, irq_clear coinciding with DONE entry, then a real clear
    run_pass(0, 16, 1'b1);
    irq_clear = 1'b1;
    @(negedge clk);
    irq_clear = 1'b0;
    check_eq("irq_clear", 64'(done_irq), 64'd0);

    // random ranges with random corrupted words, each started from DONE
    for (int t = 0; t < 6; t++) begin
      int b, l, nc;
      b  = $urandom_range(0, DEPTH - 1);
      l  = $urandom_range(0, 48);
      nc = $urandom_range(0, 3);
      for (int j = 0; j < nc && l > 0; j++)
        corrupt[(b + int'($urandom_range(0, l - 1))) % int'(DEPTH)] = $urandom | 32'h1;
      run_pass(b, l, 1'b0);
      clear_corrupt();
    end

    // oversized length clamps to DEPTH; every word corrupted
    for (int i = 0; i < int'(DEPTH); i++) corrupt[i] = 32'h8000_0000;
    run_pass($urandom_range(0, DEPTH - 1), 16383, 1'b0);
    clear_corrupt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
